// File: rtl/evo_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : evo_truth_table_sweeper
// Description : Walks every input vector of an evolved LCELL circuit in
//               ascending order, lets each vector settle, samples the
//               synchronised output several times and builds the measured
//               truth table plus a per-vector instability mask.
// Revision    : 1.0 - initial release
// ============================================================================
module evo_truth_table_sweeper #(
  parameter int IN_WIDTH      = 5,
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_COUNT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     dut_out,
  output logic [IN_WIDTH-1:0]      dut_in,
  output logic                     busy,
  output logic                     done,
  output logic [2**IN_WIDTH-1:0]   truth_table,
  output logic [2**IN_WIDTH-1:0]   unstable_mask,
  output logic                     unstable_any
);

  localparam int                  c_NVEC        = 2**IN_WIDTH;
  localparam logic [7:0]          c_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]          c_SAMPLE_LAST = 8'(SAMPLE_COUNT - 1);
  localparam logic [IN_WIDTH-1:0] c_LAST_VEC    = {IN_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_STORE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync_q;
  logic [7:0]          r_cnt;
  logic [IN_WIDTH-1:0] r_vector;
  logic                r_busy;
  logic                r_done;
  logic [c_NVEC-1:0]   r_tt;
  logic [c_NVEC-1:0]   r_um;
  logic                r_any;
  logic                r_ref;
  logic                r_diff;

  logic [c_NVEC-1:0]   w_tt_next;
  logic [c_NVEC-1:0]   w_um_next;
  logic                w_last_vec;

  assign w_last_vec = (r_vector == c_LAST_VEC);

  // Result words with the current vector's measurement merged in.
  always_comb begin
    w_tt_next           = r_tt;
    w_um_next           = r_um;
    w_tt_next[r_vector] = r_ref;
    w_um_next[r_vector] = r_diff;
  end

  // Two-flop synchroniser for the asynchronous, possibly oscillating output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_sync1  <= dut_out;
      r_sync_q <= r_sync1;
    end
  end

  // Sweep sequencer: settle, sample, store for each vector, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_vector <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tt     <= '0;
      r_um     <= '0;
      r_any    <= 1'b0;
      r_ref    <= 1'b0;
      r_diff   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vector <= '0;
            r_tt     <= '0;
            r_um     <= '0;
            r_any    <= 1'b0;
            r_cnt    <= 8'd0;
            r_busy   <= 1'b1;
            r_state  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == c_SETTLE_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SAMPLE: begin
          // First sample becomes the reference; later ones accumulate disagreement.
          if (r_cnt == 8'd0) begin
            r_ref  <= r_sync_q;
            r_diff <= 1'b0;
          end else begin
            r_diff <= r_diff | (r_sync_q ^ r_ref);
          end
          if (r_cnt == c_SAMPLE_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_STORE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_STORE: begin
          r_tt  <= w_tt_next;
          r_um  <= w_um_next;
          r_any <= |w_um_next;
          if (w_last_vec) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_vector <= r_vector + IN_WIDTH'(1);
            r_cnt    <= 8'd0;
            r_state  <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dut_in        = r_vector;
  assign busy          = r_busy;
  assign done          = r_done;
  assign truth_table   = r_tt;
  assign unstable_mask = r_um;
  assign unstable_any  = r_any;

endmodule
`default_nettype wire

// File: tb/tb_evo_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_evo_truth_table_sweeper
// Description : Self-checking bench for evo_truth_table_sweeper using three
//               parameterisations and behavioural models of evolved circuits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evo_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, start_b, start_c;
  logic        out_a, out_b, out_c;
  logic [4:0]  in_a, in_b, in_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [31:0] tt_a, tt_b, tt_c;
  logic [31:0] um_a, um_b, um_c;
  logic        any_a, any_b, any_c;

  evo_truth_table_sweeper #(.IN_WIDTH(5), .SETTLE_CYCLES(16), .SAMPLE_COUNT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(out_a), .dut_in(in_a),
    .busy(busy_a), .done(done_a), .truth_table(tt_a), .unstable_mask(um_a),
    .unstable_any(any_a));
  evo_truth_table_sweeper #(.IN_WIDTH(5), .SETTLE_CYCLES(3), .SAMPLE_COUNT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(out_b), .dut_in(in_b),
    .busy(busy_b), .done(done_b), .truth_table(tt_b), .unstable_mask(um_b),
    .unstable_any(any_b));
  evo_truth_table_sweeper #(.IN_WIDTH(5), .SETTLE_CYCLES(3), .SAMPLE_COUNT(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .dut_out(out_c), .dut_in(in_c),
    .busy(busy_c), .done(done_c), .truth_table(tt_c), .unstable_mask(um_c),
    .unstable_any(any_c));

  // Evolved-circuit models: parity / oscillator, constant / lookup, delayed parity.
  int          mode_a = 0;
  int          mode_b = 0;
  logic [31:0] tbl_b  = 32'h0;
  logic        osc    = 1'b0;
  logic [4:0]  dly_c  = 5'b0;
  always @(posedge clk) osc <= ~osc;
  always @(posedge clk) dly_c <= {dly_c[3:0], ^in_c};
  assign out_a = (mode_a == 0) ? ^in_a : ((in_a == 5'd7) ? osc : 1'b0);
  assign out_b = (mode_b == 0) ? 1'b1 : tbl_b[in_b];
  assign out_c = dly_c[4];

  // Edge history: h_x[p] is the circuit output present at posedge number p.
  int   cyc = 0;
  logic h_a [0:8191];
  logic h_b [0:8191];
  logic h_c [0:8191];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    h_a[cyc % 8192] = out_a;
    h_b[cyc % 8192] = out_b;
    h_c[cyc % 8192] = out_c;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hv(input int id, input int e);
    if (e < 0) return 1'b0;
    case (id)
      0:       return h_a[e % 8192];
      1:       return h_b[e % 8192];
      default: return h_c[e % 8192];
    endcase
  endfunction

  // Reference: vector v holds from edge a+v*P; its samples are taken at edges
  // a+v*P+S+1+j and see the circuit output from two edges earlier.
  task automatic ref_sweep(input int id, input int a, input int s, input int c,
                           output logic [31:0] tt, output logic [31:0] um);
    logic first, x;
    tt = '0; um = '0; first = 1'b0;
    for (int v = 0; v < 32; v++) begin
      for (int j = 0; j < c; j++) begin
        x = hv(id, a + v * (s + c + 1) + s + 1 + j - 2);
        if (j == 0) first = x;
        else if (x !== first) um[v] = 1'b1;
      end
      tt[v] = first;
    end
  endtask

  function automatic logic get_busy(input int id);
    return (id == 0) ? busy_a : (id == 1) ? busy_b : busy_c;
  endfunction
  function automatic logic get_done(input int id);
    return (id == 0) ? done_a : (id == 1) ? done_b : done_c;
  endfunction
  function automatic logic [31:0] get_tt(input int id);
    return (id == 0) ? tt_a : (id == 1) ? tt_b : tt_c;
  endfunction
  function automatic logic [31:0] get_um(input int id);
    return (id == 0) ? um_a : (id == 1) ? um_b : um_c;
  endfunction
  function automatic logic get_any(input int id);
    return (id == 0) ? any_a : (id == 1) ? any_b : any_c;
  endfunction
  task automatic drive_start(input int id, input logic v);
    case (id)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  logic [31:0] snap_tt, snap_um;
  logic        snap_any;

  // One start pulse, optional extra start pulses at offsets p1/p2, bounded wait.
  task automatic run_sweep(input int id, input int p1, input int p2, input int limit,
                           output int a, output int dedge, output int nbusy, output int ndone);
    dedge = -1; nbusy = 0; ndone = 0;
    @(negedge clk);
    a = cyc;
    drive_start(id, 1'b1);
    @(negedge clk);
    drive_start(id, 1'b0);
    snap_tt  = get_tt(id);
    snap_um  = get_um(id);
    snap_any = get_any(id);
    for (int k = 0; k < limit; k++) begin
      if (get_busy(id)) nbusy++;
      if (get_done(id)) begin
        ndone++;
        if (dedge < 0) dedge = cyc - 1;
      end
      drive_start(id, (cyc - a == p1) || (cyc - a == p2));
      if (dedge >= 0 && cyc - 1 >= dedge + 4) break;
      @(negedge clk);
    end
    drive_start(id, 1'b0);
  endtask

  int          a, dedge, nbusy, ndone, k, rst_at;
  logic [31:0] rtt, rum, cf_um, cf_tt;

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    tbl_b = $urandom;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_din", in_a, 5'd0);
    chk("rst_tt_um_any", {tt_a, um_a, any_a}, 65'd0);
    rst_n = 1'b1;
    repeat (2 + $urandom_range(0, 3)) @(negedge clk);

    // Parity sweep with ignored start pulses at cycles 50 and 400.
    mode_a = 0;
    run_sweep(0, 50, 400, 900, a, dedge, nbusy, ndone);
    chk("par_done_edge", dedge - a, 800);
    chk("par_busy_cycles", nbusy, 800);
    chk("par_done_pulses", ndone, 1);
    chk("par_tt", tt_a, 32'h96696996);
    chk("par_um", um_a, 32'h0);
    chk("par_any", any_a, 1'b0);
    chk("par_busy_after", busy_a, 1'b0);
    chk("par_din_last", in_a, 5'd31);
    ref_sweep(0, a, 16, 8, rtt, rum);
    chk("par_tt_ref", tt_a, rtt);

    // Oscillating loop on vector 7.
    mode_a = 1;
    run_sweep(0, -1, -1, 900, a, dedge, nbusy, ndone);
    ref_sweep(0, a, 16, 8, rtt, rum);
    chk("osc_done_edge", dedge - a, 800);
    chk("osc_um", um_a, 32'h00000080);
    chk("osc_um_ref", um_a, rum);
    chk("osc_any", any_a, 1'b1);
    chk("osc_tt_others", tt_a & ~32'h80, 32'h0);
    chk("osc_tt7_ref", tt_a[7], rtt[7]);

    // Restart after DONE with parity: results clear at the accept edge.
    mode_a = 0;
    run_sweep(0, -1, -1, 900, a, dedge, nbusy, ndone);
    chk("restart_clr_tt", snap_tt, 32'h0);
    chk("restart_clr_um", snap_um, 32'h0);
    chk("restart_clr_any", snap_any, 1'b0);
    chk("restart_tt", tt_a, 32'h96696996);
    chk("restart_any", any_a, 1'b0);

    // Asynchronous reset during the vector-12 sample window.
    @(negedge clk);
    a = cyc;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rst_at = a + 12 * 25 + 17 + $urandom_range(0, 6);
    while (cyc - 1 < rst_at) @(negedge clk);
    chk("rst_pre_tt_nonzero", (tt_a != 32'h0), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_din", in_a, 5'd0);
    chk("mid_rst_tt_um_any_done", {tt_a, um_a, any_a, done_a}, 66'd0);
    ndone = 0;
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    chk("mid_rst_idle", busy_a, 1'b0);
    run_sweep(0, -1, -1, 900, a, dedge, nbusy, ndone);
    chk("post_rst_done_edge", dedge - a, 800);
    chk("post_rst_tt", tt_a, 32'h96696996);

    // Constant-1 circuit with short settle and single sample.
    mode_b = 0;
    run_sweep(1, -1, -1, 250, a, dedge, nbusy, ndone);
    chk("c1_done_edge", dedge - a, 160);
    chk("c1_busy_cycles", nbusy, 160);
    chk("c1_tt", tt_b, 32'hFFFFFFFF);
    chk("c1_um", um_b, 32'h0);

    // Random lookup-table circuit.
    mode_b = 1;
    run_sweep(1, -1, -1, 250, a, dedge, nbusy, ndone);
    chk("rnd_tt", tt_b, tbl_b);
    chk("rnd_um", um_b, 32'h0);
    chk("rnd_any", any_b, 1'b0);

    // Slow circuit: parity delayed 5 clocks, settle shorter than the delay.
    run_sweep(2, -1, -1, 500, a, dedge, nbusy, ndone);
    ref_sweep(2, a, 3, 8, rtt, rum);
    chk("slow_done_edge", dedge - a, 384);
    chk("slow_um_ref", um_c, rum);
    chk("slow_tt_ref", tt_c, rtt);
    cf_um = '0; cf_tt = '0;
    for (int v = 1; v < 32; v++) begin
      cf_um[v] = (^v[4:0]) ^ (^(v - 1));
      cf_tt[v] = ^(v - 1);
    end
    chk("slow_um_adjacent", um_c & 32'hFFFFFFFE, cf_um);
    chk("slow_tt_previous", tt_c & 32'hFFFFFFFE, cf_tt);
    chk("slow_any", any_c, |rum);
    chk("slow_idle", busy_c, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
